// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

    localparam int FETCH_A    = 12;
    localparam int FETCH_OFFW = 6;
    localparam int FETCH_CNTW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection with wrap detection.
module pc_next_calc #(
    parameter int A    = 12,
    parameter int OFFW = 6
) (
    input  logic [A-1:0]    pc,
    input  logic            stall,
    input  logic            branch_abs,
    input  logic            branch_rel,
    input  logic [A-1:0]    target,
    input  logic [OFFW-1:0] offset,
    output logic [A-1:0]    next_pc,
    output logic            wrap
);

    logic [A:0]   seq_full;
    logic [A+1:0] off_ext;
    logic [A+1:0] rel_full;
    logic         take_abs;
    logic         take_rel;

    assign take_abs = !stall && branch_abs;
    assign take_rel = !stall && !branch_abs && branch_rel;

    assign seq_full = {1'b0, pc} + {{A{1'b0}}, 1'b1};
    assign off_ext  = {{(A+2-OFFW){offset[OFFW-1]}}, offset};
    // Two guard bits: bit A flags overflow, bit A+1 flags a negative result.
    assign rel_full = {2'b00, pc} + off_ext;

    always_comb begin
        next_pc = pc;
        wrap    = 1'b0;
        unique case (1'b1)
            stall: begin
                next_pc = pc;
            end
            take_abs: begin
                next_pc = target;
            end
            take_rel: begin
                next_pc = rel_full[A-1:0];
                wrap    = rel_full[A+1] | rel_full[A];
            end
            default: begin
                next_pc = seq_full[A-1:0];
                wrap    = seq_full[A];
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, runs the Start/Done handshake,
// counts retired instructions and tracks PC wrap.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int A    = FETCH_A,
    parameter int OFFW = FETCH_OFFW,
    parameter int CNTW = FETCH_CNTW
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            BranchAbs,
    input  logic            BranchRel,
    input  logic [A-1:0]    Target,
    input  logic [OFFW-1:0] Offset,
    output logic [A-1:0]    ProgCtr,
    output logic            FetchValid,
    output logic            Done,
    output logic            Wrapped,
    output logic [CNTW-1:0] InstrCount
);

    fetch_state_t    state;
    logic [A-1:0]    next_pc;
    logic            wrap;
    logic [CNTW-1:0] cnt_inc;

    pc_next_calc #(
        .A    (A),
        .OFFW (OFFW)
    ) u_pc_next (
        .pc         (ProgCtr),
        .stall      (Stall),
        .branch_abs (BranchAbs),
        .branch_rel (BranchRel),
        .target     (Target),
        .offset     (Offset),
        .next_pc    (next_pc),
        .wrap       (wrap)
    );

    assign cnt_inc = (InstrCount == {CNTW{1'b1}}) ?
                     InstrCount : InstrCount + CNTW'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ProgCtr    <= '0;
            FetchValid <= 1'b0;
            Done       <= 1'b0;
            Wrapped    <= 1'b0;
            InstrCount <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state      <= RUN;
                        ProgCtr    <= '0;
                        FetchValid <= 1'b1;
                        Done       <= 1'b0;
                        Wrapped    <= 1'b0;
                        InstrCount <= '0;
                    end
                end
                RUN: begin
                    // Halt outranks Stall; the PC stays on the halt instruction.
                    if (Halt) begin
                        state      <= DONE;
                        FetchValid <= 1'b0;
                        Done       <= 1'b1;
                        InstrCount <= cnt_inc;
                    end else if (!Stall) begin
                        ProgCtr    <= next_pc;
                        Wrapped    <= Wrapped | wrap;
                        InstrCount <= cnt_inc;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ProgCtr    <= '0;
                    FetchValid <= 1'b0;
                    Done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
